// File: rtl/clock_pkg.sv
// Shared types and helpers for the multiplexed display scanner.
// onehot() returns a wide vector; callers size-cast it down to their channel count.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

    localparam int MAX_CHANNELS = 32;

    function automatic logic [MAX_CHANNELS-1:0] onehot(input int unsigned idx);
        logic [MAX_CHANNELS-1:0] v;
        v = {{(MAX_CHANNELS-1){1'b0}}, 1'b1} << idx;
        return v;
    endfunction

endpackage

// File: rtl/scan_next_sel.sv
// Rotate-priority search for the next enabled channel after sel_i, wrapping at CHANNELS-1.
// When only sel_i itself is enabled, the search comes back round and returns sel_i.
module scan_next_sel #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [SEL_W-1:0]    sel_i,
    input  logic [CHANNELS-1:0] mask_i,
    output logic [SEL_W-1:0]    next_sel_o,
    output logic                any_enabled_o
);

    logic [SEL_W-1:0] cand;
    logic             found;

    always_comb begin
        next_sel_o    = sel_i;
        any_enabled_o = |mask_i;
        cand          = sel_i;
        found         = 1'b0;
        for (int n = 0; n < CHANNELS; n++) begin
            cand = (cand == SEL_W'(CHANNELS - 1)) ? '0 : cand + SEL_W'(1);
            if (!found && mask_i[cand]) begin
                next_sel_o = cand;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed N-channel digit selector: scan counter, channel mask,
// anti-ghosting blank interval and registered one-hot digit enables.
module display_scan_mux
    import clock_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int CHANNELS     = 4,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int SEL_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    input  logic [CHANNELS-1:0]       ch_mask_i,
    output logic [WIDTH-1:0]          data_o,
    output logic [SEL_W-1:0]          sel_o,
    output logic [CHANNELS-1:0]       an_o,
    output logic                      slot_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
    // With no blank interval a new slot lands directly in SHOW.
    localparam scan_state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    scan_state_t         state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [CHANNELS-1:0] an_q, an_d;
    logic                slot_q, slot_d;

    logic [SEL_W-1:0]    next_sel;
    logic                any_enabled;
    logic [WIDTH-1:0]    data_sel;

    scan_next_sel #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_next_sel (
        .sel_i         (sel_q),
        .mask_i        (ch_mask_i),
        .next_sel_o    (next_sel),
        .any_enabled_o (any_enabled)
    );

    always_comb begin
        data_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (sel_q == SEL_W'(k)) begin
                data_sel = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sel_d   = sel_q;
        data_d  = data_q;
        an_d    = '0;
        slot_d  = 1'b0;

        if (!en) begin
            state_d = IDLE;
            presc_d = '0;
        end else begin
            data_d = data_sel;
            case (state_q)
                IDLE: begin
                    state_d = SLOT_START;
                    presc_d = '0;
                    slot_d  = 1'b1;
                end
                default: begin
                    if (presc_q == PRESC_LAST) begin
                        state_d = SLOT_START;
                        presc_d = '0;
                        slot_d  = 1'b1;
                        if (any_enabled) begin
                            sel_d = next_sel;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                        if (state_q == BLANK && presc_q == BLANK_LAST) begin
                            state_d = SHOW;
                        end
                    end
                end
            endcase
            // Enables are computed from the next state so an_o lines up with state_q.
            if (state_d == SHOW && ch_mask_i[sel_d]) begin
                an_d = CHANNELS'(onehot(int'(sel_d)));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            sel_q   <= '0;
            data_q  <= '0;
            an_q    <= '0;
            slot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            an_q    <= an_d;
            slot_q  <= slot_d;
        end
    end

    assign data_o = data_q;
    assign sel_o  = sel_q;
    assign an_o   = an_q;
    assign slot_o = slot_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: directed scenarios plus random traffic, checked every
// cycle against a slot/phase reference model of the scanning behaviour.
module tb_display_scan_mux;

    localparam int W  = 4;
    localparam int C  = 4;
    localparam int P  = 8;
    localparam int B  = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [C*W-1:0] data_i = '0;
    logic [C-1:0]  ch_mask_i = '0;
    logic [W-1:0]  data_o;
    logic [SW-1:0] sel_o;
    logic [C-1:0]  an_o;
    logic          slot_o;

    display_scan_mux #(
        .WIDTH        (W),
        .CHANNELS     (C),
        .PRESCALE     (P),
        .BLANK_CYCLES (B)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .data_i    (data_i),
        .ch_mask_i (ch_mask_i),
        .data_o    (data_o),
        .sel_o     (sel_o),
        .an_o      (an_o),
        .slot_o    (slot_o)
    );

    always #5 clk = ~clk;

    // Reference model: whether scanning, current channel, cycles into the slot.
    bit           m_active;
    int           m_sel;
    int           m_phase;
    logic [W-1:0] m_data;
    logic [C-1:0] m_an;
    logic         m_slot;

    int n_chk = 0;
    int n_pass = 0;

    function automatic int next_ch(input int s, input logic [C-1:0] m);
        for (int i = 1; i <= C; i++) begin
            if (m[(s + i) % C]) return (s + i) % C;
        end
        return s;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_sel    = 0;
        m_phase  = 0;
        m_data   = '0;
        m_an     = '0;
        m_slot   = 1'b0;
    endtask

    task automatic model_edge();
        if (!en) begin
            m_active = 0;
            m_slot   = 1'b0;
        end else begin
            m_data = data_i[m_sel*W +: W];
            if (!m_active) begin
                m_active = 1;
                m_phase  = 0;
                m_slot   = 1'b1;
            end else if (m_phase == P - 1) begin
                m_sel   = next_ch(m_sel, ch_mask_i);
                m_phase = 0;
                m_slot  = 1'b1;
            end else begin
                m_phase = m_phase + 1;
                m_slot  = 1'b0;
            end
        end
        m_an = (m_active && m_phase >= B && ch_mask_i[m_sel]) ? C'(1 << m_sel) : '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_data"}, 32'(data_o), 32'(m_data));
        chk({tag, "_sel"},  32'(sel_o),  32'(m_sel));
        chk({tag, "_an"},   32'(an_o),   32'(m_an));
        chk({tag, "_slot"}, 32'(slot_o), 32'(m_slot));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all("cyc");
    endtask

    task automatic run(input int n, input bit rnd_data);
        for (int i = 0; i < n; i++) begin
            if (rnd_data) data_i = 16'($urandom);
            step();
        end
    endtask

    task automatic wait_for(input int sel, input int phase);
        int k;
        k = 0;
        while (!(m_active && m_sel == sel && m_phase == phase) && k < 100) begin
            step();
            k++;
        end
        chk("wait_sel", 32'(m_sel), 32'(sel));
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_an",   32'(an_o),   32'h0);
        chk("rst_sel",  32'(sel_o),  32'h0);
        chk("rst_data", 32'(data_o), 32'h0);
        chk("rst_slot", 32'(slot_o), 32'h0);
        rst_n = 1'b1;
        step();

        // Full mask, fixed digits 4,3,2,1.
        data_i    = 16'h4321;
        ch_mask_i = 4'b1111;
        en        = 1'b1;
        run(41, 0);
        wait_for(1, 3);
        chk("ch1_data", 32'(data_o), 32'h2);
        chk("ch1_an",   32'(an_o),   32'b0010);

        // Sparse mask: channels 0 and 2 only.
        ch_mask_i = 4'b0101;
        run(40, 1);

        // Empty mask: dark display, slots keep pulsing.
        ch_mask_i = 4'b0000;
        run(24, 1);

        // Disable mid-SHOW on channel 2, then resume.
        ch_mask_i = 4'b1111;
        data_i    = 16'h4321;
        wait_for(2, 4);
        en = 1'b0;
        step();
        chk("en0_an",  32'(an_o),  32'h0);
        chk("en0_sel", 32'(sel_o), 32'h2);
        run(3, 0);
        en = 1'b1;
        step();
        chk("resume_slot", 32'(slot_o), 32'h1);
        step();
        step();
        chk("resume_an", 32'(an_o), 32'b0100);

        // Clear channel 1 mid-SHOW: dark next cycle, advance to 2 at slot end.
        wait_for(1, 4);
        ch_mask_i = 4'b1101;
        step();
        chk("clr_an", 32'(an_o), 32'h0);
        wait_for(2, 0);
        ch_mask_i = 4'b1111;

        // Asynchronous reset mid-scan.
        wait_for(3, 5);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_an",   32'(an_o),   32'h0);
        chk("arst_sel",  32'(sel_o),  32'h0);
        chk("arst_data", 32'(data_o), 32'h0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        run(20, 0);

        // Random traffic: enable drops, mask changes, changing digits.
        for (int i = 0; i < 400; i++) begin
            en     = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) ch_mask_i = 4'($urandom);
            data_i = 16'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
